shapool_ctrl: RTL

Job-side controller for the `shapool` hashing core.
- Accepts a byte stream carrying one job (SHA midstate, message head, difficulty) plus the device nonce-start byte, and registers these as the core's parameters.
- Resets and runs the core for a bounded number of 64-cycle nonce rounds.
- Captures `success`/`nonce` and streams a 5-byte result back out.
- Sits between the host link (SPI/UART byte layer) and `shapool`; it is the reader of job parameters and the writer of results.

---
 rtl/shapool_ctrl_pkg.sv | 32 +++
 rtl/shapool_ctrl_job_shift_reg.sv | 48 ++++
 rtl/shapool_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/shapool_ctrl_pkg.sv
// Shared definitions for the shapool job controller: state encoding,
// job/result sizes, status codes and field positions in the job register.
package shapool_ctrl_pkg;

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_RUN    = 2'd1,
      S_REPORT = 2'd2
   } state_e;

   localparam int JOB_BYTES    = 32'd46;
   localparam int RESULT_BYTES = 32'd5;
   localparam int JOB_BITS     = JOB_BYTES * 32'd8;

   localparam logic [5:0] LAST_JOB_IDX = 6'(JOB_BYTES - 32'd1);
   localparam logic [2:0] LAST_RES_IDX = 3'(RESULT_BYTES - 32'd1);

   localparam logic [7:0] ST_EXHAUSTED = 8'h00;
   localparam logic [7:0] ST_FOUND     = 8'h01;
   localparam logic [7:0] ST_HALTED    = 8'h02;

   // Field widths and LSB offsets; the first byte received lands in the MSB.
   localparam int SHA_STATE_W    = 32'd256;
   localparam int MSG_HEAD_W     = 32'd96;
   localparam int DIFF_W         = 32'd8;
   localparam int NONCE_MSB_W    = 32'd8;
   localparam int NONCE_MSB_LSB  = 32'd0;
   localparam int DIFF_LSB       = NONCE_MSB_LSB + NONCE_MSB_W;
   localparam int MSG_HEAD_LSB   = DIFF_LSB + DIFF_W;
   localparam int SHA_STATE_LSB  = MSG_HEAD_LSB + MSG_HEAD_W;

endpackage

// File: rtl/shapool_ctrl_job_shift_reg.sv
// Byte-wide job shift register: accepted bytes shift in MSB-first, a byte
// counter tracks progress, and done pulses on the byte that completes a job.
module job_shift_reg
   import shapool_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                shift_en,
   input  logic [7:0]          byte_in,
   output logic [JOB_BITS-1:0] job,
   output logic                done
);

   logic [JOB_BITS-1:0] job_d, job_q;
   logic [5:0]          cnt_d, cnt_q;

   // Shift an accepted byte in and count it; wrap the count on the last byte.
   always_comb begin
      job_d = job_q;
      cnt_d = cnt_q;
      done  = 1'b0;
      if (shift_en) begin
         job_d = {job_q[JOB_BITS-9:0], byte_in};
         if (cnt_q == LAST_JOB_IDX) begin
            cnt_d = 6'd0;
            done  = 1'b1;
         end else begin
            cnt_d = cnt_q + 6'd1;
         end
      end else begin
         job_d = job_q;
      end
   end

   // Job register and byte counter; reset discards any partial job.
   always_ff @(posedge clk) begin
      if (reset) begin
         job_q <= {JOB_BITS{1'b0}};
         cnt_q <= 6'd0;
      end else begin
         job_q <= job_d;
         cnt_q <= cnt_d;
      end
   end

   assign job = job_q;

endmodule

// File: rtl/shapool_ctrl.sv
// Job-side controller for the shapool hashing core: loads a 46-byte job,
// holds the core out of reset for a bounded number of nonce rounds, then
// streams a 5-byte result (status + nonce) back to the host.
module shapool_ctrl
   import shapool_ctrl_pkg::*;
#(
   parameter int MAX_ROUNDS   = 32'd100,
   parameter int ROUND_CYCLES = 32'd64
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         halt,
   output logic [255:0] sha_state,
   output logic [95:0]  message_head,
   output logic [7:0]   difficulty,
   output logic [7:0]   nonce_start_MSB,
   output logic         pool_reset_n,
   input  logic         success,
   input  logic [31:0]  nonce,
   output logic         busy
);

   localparam int               TOTAL_CYCLES = MAX_ROUNDS * ROUND_CYCLES;
   localparam int               CYC_W        = $clog2(TOTAL_CYCLES + 32'd1);
   localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(TOTAL_CYCLES - 32'd1);
   localparam logic [CYC_W-1:0] CYC_ONE      = CYC_W'(32'd1);

   state_e              state_d, state_q;
   logic [CYC_W-1:0]    cyc_d, cyc_q;
   logic [2:0]          res_idx_d, res_idx_q;
   logic [7:0]          status_d, status_q;
   logic [31:0]         nonce_d, nonce_q;
   logic [JOB_BITS-1:0] job_s;
   logic                job_done_s;
   logic                shift_en_s;

   // Bytes are only taken while loading; in_ready already encodes that.
   assign shift_en_s = in_valid & in_ready;

   job_shift_reg u_job (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en_s),
      .byte_in  (in_data),
      .job      (job_s),
      .done     (job_done_s)
   );

   assign sha_state       = job_s[SHA_STATE_LSB +: SHA_STATE_W];
   assign message_head    = job_s[MSG_HEAD_LSB +: MSG_HEAD_W];
   assign difficulty      = job_s[DIFF_LSB +: DIFF_W];
   assign nonce_start_MSB = job_s[NONCE_MSB_LSB +: NONCE_MSB_W];

   // Handshake and core-control outputs depend on the state register only.
   always_comb begin
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      pool_reset_n = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
         end
         S_RUN: begin
            busy         = 1'b1;
            pool_reset_n = 1'b1;
         end
         S_REPORT: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Result byte offered to the host: status first, then nonce MSB-first.
   always_comb begin
      out_data = 8'h00;
      if (state_q == S_REPORT) begin
         case (res_idx_q)
            3'd0:    out_data = status_q;
            3'd1:    out_data = nonce_q[31:24];
            3'd2:    out_data = nonce_q[23:16];
            3'd3:    out_data = nonce_q[15:8];
            3'd4:    out_data = nonce_q[7:0];
            default: out_data = 8'h00;
         endcase
      end else begin
         out_data = 8'h00;
      end
   end

   // Next-state logic: load -> run -> report -> load, with success taking
   // priority over halt, and halt over round exhaustion.
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      res_idx_d = res_idx_q;
      status_d  = status_q;
      nonce_d   = nonce_q;
      case (state_q)
         S_LOAD: begin
            if (job_done_s) begin
               state_d = S_RUN;
               cyc_d   = {CYC_W{1'b0}};
            end else begin
               state_d = S_LOAD;
            end
         end
         S_RUN: begin
            if (success) begin
               nonce_d   = nonce;
               status_d  = ST_FOUND;
               state_d   = S_REPORT;
               cyc_d     = {CYC_W{1'b0}};
               res_idx_d = 3'd0;
            end else if (halt) begin
               nonce_d   = nonce;
               status_d  = ST_HALTED;
               state_d   = S_REPORT;
               cyc_d     = {CYC_W{1'b0}};
               res_idx_d = 3'd0;
            end else if (cyc_q == CYC_LAST) begin
               nonce_d   = nonce;
               status_d  = ST_EXHAUSTED;
               state_d   = S_REPORT;
               cyc_d     = {CYC_W{1'b0}};
               res_idx_d = 3'd0;
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end
         S_REPORT: begin
            if (out_ready) begin
               if (res_idx_q == LAST_RES_IDX) begin
                  res_idx_d = 3'd0;
                  state_d   = S_LOAD;
               end else begin
                  res_idx_d = res_idx_q + 3'd1;
               end
            end else begin
               res_idx_d = res_idx_q;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // State, run counter, result index and captured result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_LOAD;
         cyc_q     <= {CYC_W{1'b0}};
         res_idx_q <= 3'd0;
         status_q  <= 8'h00;
         nonce_q   <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         res_idx_q <= res_idx_d;
         status_q  <= status_d;
         nonce_q   <= nonce_d;
      end
   end

endmodule
